// File: rtl/file_stream_controller.sv
// rtl/file_stream_controller.sv - sequenced file-memory reader streaming bytes over valid/ready
//
// Reads a run of bytes from a 1-cycle-latency synchronous memory, starting at
// a command base address, and presents them one per cycle on a valid/ready
// stream. A 2-entry output buffer plus read-credit accounting means the
// consumer may stall at any time without a byte being lost or repeated.
//
// Build option:
//   FILE_STREAM_LOOP_EN - when defined, a transfer started with i_loop high
//                         restarts at the base address after every pass and
//                         only ends on i_abort or reset. When undefined,
//                         i_loop is ignored.
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   i_start         in   command strobe, honoured in IDLE only
//   i_base_addr     in   first address of the transfer
//   i_length        in   byte count, 0..DEPTH
//   i_loop          in   repeat transfer (FILE_STREAM_LOOP_EN builds only)
//   i_abort         in   cancel the current transfer
//   o_busy          out  high whenever not IDLE
//   o_done          out  one-cycle pulse on normal completion
//   o_mem_rd_en     out  memory read request
//   o_mem_addr      out  memory read address
//   i_mem_rd_data   in   memory data, valid the cycle after o_mem_rd_en
//   o_out_data      out  stream byte
//   o_out_valid     out  stream byte valid
//   i_out_ready     in   consumer accepts the byte
//   o_out_last      out  marks the final byte of a pass

module file_stream_controller #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_length,
    input  logic              i_loop,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched command
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic              r_loop;

    // Read sequencing
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;

    // Output buffer: entry 0 is the head
    logic [DATA_W-1:0] r_buf_data0;
    logic [DATA_W-1:0] r_buf_data1;
    logic              r_buf_last0;
    logic              r_buf_last1;
    logic [1:0]        r_count;

    logic              w_loop_cmd;
    logic              w_accept;
    logic              w_flush;
    logic              w_pop;
    logic              w_push;
    logic              w_pass_end;
    logic              w_credit;
    logic [2:0]        w_occ_after;
    logic [ADDR_W-1:0] w_ptr_inc;

`ifdef FILE_STREAM_LOOP_EN
    assign w_loop_cmd = i_loop;
`else
    // Loop support is compiled out; the input is deliberately discarded.
    assign w_loop_cmd = i_loop & 1'b0;
`endif

    // A start coinciding with abort is dropped so abort always wins.
    assign w_accept    = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_flush     = (r_state != S_IDLE) && i_abort;

    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_buf_data0;
    assign o_out_last  = o_out_valid && r_buf_last0;
    assign o_mem_addr  = r_rd_ptr;

    assign w_pop       = o_out_valid && i_out_ready;
    assign w_push      = r_inflight;

    // The read issued this cycle is the final address of its pass.
    assign w_pass_end  = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

    // Slots already claimed once this cycle's pop is accounted for: buffered
    // bytes plus the byte returning from memory. A new read may only be
    // issued if that leaves room for it when it returns next cycle.
    assign w_occ_after = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit    = (w_occ_after < 3'd2);

    assign w_ptr_inc   = (r_rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and control outputs
    always_comb begin
        w_next_state = r_state;
        o_busy       = (r_state != S_IDLE);
        o_done       = 1'b0;
        o_mem_rd_en  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (i_length == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    o_mem_rd_en = w_credit;
                    if (w_credit && w_pass_end && !r_loop) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_pop && r_buf_last0) begin
                    w_next_state = S_DONE;
                end
            end

            S_DONE: begin
                o_done       = !i_abort;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Command latch and read pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_base      <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_base      <= i_base_addr;
            r_len       <= i_length;
            r_loop      <= w_loop_cmd;
            r_rd_ptr    <= i_base_addr;
            r_remaining <= i_length;
        end else if (o_mem_rd_en) begin
            if (w_pass_end && r_loop) begin
                // Seamless restart of the next pass.
                r_rd_ptr    <= r_base;
                r_remaining <= r_len;
            end else begin
                r_rd_ptr    <= w_ptr_inc;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    // In-flight read tracking; an abort discards the pending return.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else if (w_flush) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= o_mem_rd_en;
            r_inflight_last <= o_mem_rd_en && w_pass_end;
        end
    end

    // Two-entry output buffer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf_data0 <= '0;
            r_buf_data1 <= '0;
            r_buf_last0 <= 1'b0;
            r_buf_last1 <= 1'b0;
            r_count     <= 2'd0;
        end else if (w_flush) begin
            r_count     <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf_data0 <= i_mem_rd_data;
                        r_buf_last0 <= r_inflight_last;
                    end else begin
                        r_buf_data1 <= i_mem_rd_data;
                        r_buf_last1 <= r_inflight_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf_data0 <= r_buf_data1;
                    r_buf_last0 <= r_buf_last1;
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf_data0 <= i_mem_rd_data;
                        r_buf_last0 <= r_inflight_last;
                    end else begin
                        r_buf_data0 <= r_buf_data1;
                        r_buf_last0 <= r_buf_last1;
                        r_buf_data1 <= i_mem_rd_data;
                        r_buf_last1 <= r_inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_file_stream_controller.sv
// tb/tb_file_stream_controller.sv - directed self-checking bench for file_stream_controller

module tb_file_stream_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] base_addr = '0;
    logic [7:0] length = '0;
    logic       loop = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [6:0] mem_addr;
    logic [7:0] mem_rd_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;

    logic [7:0] mem [0:127];

    int checks = 0;
    int failures = 0;

    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_bcyc[$];
    int         q_addr[$];
    int         q_rcyc[$];
    int         q_done[$];
    int         busy_low_cyc;
    int         credit_viol;
    int         stall_viol;
    int         valid_after_abort;

    always #5 clock = ~clock;

    file_stream_controller dut (
        .clock         (clock),
        .reset         (reset),
        .i_start       (start),
        .i_base_addr   (base_addr),
        .i_length      (length),
        .i_loop        (loop),
        .i_abort       (abort),
        .o_busy        (busy),
        .o_done        (done),
        .o_mem_rd_en   (mem_rd_en),
        .o_mem_addr    (mem_addr),
        .i_mem_rd_data (mem_rd_data),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_last    (out_last)
    );

    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1);
    end

    // Runs one command. Entered and left just after a rising edge; cycle 0 is
    // the cycle carrying the start strobe. ready_mode: 0 high, 1 high on even
    // cycles, 2 low. A second start (ignored by a busy DUT) can be placed at s2_cyc.
    task automatic run_xfer(input int base, input int len, input bit lp, input int ready_mode,
                            input int abort_cyc, input int s2_cyc, input int base2, input int len2,
                            input int ncyc);
        int  issued;
        int  popped;
        bit  pop;
        bit  prev_stall;
        logic [7:0] prev_data;
        q_data.delete(); q_last.delete(); q_bcyc.delete();
        q_addr.delete(); q_rcyc.delete(); q_done.delete();
        busy_low_cyc = -1; credit_viol = 0; stall_viol = 0; valid_after_abort = 0;
        issued = 0; popped = 0; prev_stall = 0; prev_data = '0;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == s2_cyc);
            base_addr = (c == s2_cyc) ? 7'(base2) : 7'(base);
            length    = (c == s2_cyc) ? 8'(len2)  : 8'(len);
            loop  = lp;
            abort = (c == abort_cyc);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = (c % 2 == 0);
                default: out_ready = 1'b0;
            endcase
            @(negedge clock);
            pop = out_valid && out_ready;
            if (mem_rd_en) begin
                q_addr.push_back(int'(mem_addr));
                q_rcyc.push_back(c);
                if (issued - popped - int'(pop) >= 2) credit_viol++;
            end
            if (pop) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_bcyc.push_back(c);
            end
            if (prev_stall && !(out_valid && out_data == prev_data)) stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (done) q_done.push_back(c);
            if (c > 0 && !busy && busy_low_cyc < 0) busy_low_cyc = c;
            if (abort_cyc >= 0 && c > abort_cyc && out_valid) valid_after_abort++;
            if (mem_rd_en) issued++;
            if (pop) popped++;
            @(posedge clock); #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %0b expected 0", mem_rd_en); end
        checks++; if (mem_addr !== 7'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %0b expected 0", out_last); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_run();
        // ready low: reads in cycles 1,2, buffer full (2 bytes) from cycle 4
        run_xfer(0, 8, 1'b0, 2, -1, -1, 0, 0, 5);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrun_valid: got %0b expected 1", out_valid); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL midrun_stall: got %0b expected 0", mem_rd_en); end
        checks++; if (q_addr.size() != 2) begin failures++; $display("FAIL midrun_reads: got %0d expected 2", q_addr.size()); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrun_reset_busy: got %0b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrun_reset_valid: got %0b expected 0", out_valid); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL midrun_reset_rd_en: got %0b expected 0", mem_rd_en); end
        checks++; if (mem_addr !== 7'd0) begin failures++; $display("FAIL midrun_reset_addr: got %0d expected 0", mem_addr); end
        checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL midrun_reset_data: got %0d expected 0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL midrun_reset_last: got %0b expected 0", out_last); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        run_xfer(0, 4, 1'b0, 0, -1, -1, 0, 0, 10);
        checks++; if (q_data.size() != 4) begin failures++; $display("FAIL basic_beats: got %0d expected 4", q_data.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (q_data[k] !== 8'(k)) begin failures++; $display("FAIL basic_data%0d: got %0d expected %0d", k, q_data[k], k); end
            checks++; if (q_bcyc[k] != 3 + k) begin failures++; $display("FAIL basic_bcyc%0d: got %0d expected %0d", k, q_bcyc[k], 3 + k); end
            checks++; if (q_last[k] !== (k == 3)) begin failures++; $display("FAIL basic_last%0d: got %0b expected %0b", k, q_last[k], k == 3); end
            checks++; if (q_rcyc[k] != 1 + k) begin failures++; $display("FAIL basic_rcyc%0d: got %0d expected %0d", k, q_rcyc[k], 1 + k); end
        end
        checks++; if (q_addr.size() != 4) begin failures++; $display("FAIL basic_reads: got %0d expected 4", q_addr.size()); end
        checks++; if (q_done.size() != 1 || q_done[0] != 7) begin failures++; $display("FAIL basic_done: got n=%0d first=%0d expected n=1 cycle 7", q_done.size(), q_done[0]); end
        checks++; if (busy_low_cyc != 8) begin failures++; $display("FAIL basic_busy_low: got %0d expected 8", busy_low_cyc); end
        checks++; if (credit_viol != 0) begin failures++; $display("FAIL basic_credit: got %0d expected 0", credit_viol); end
    endtask

    task automatic test_wrap();
        int exp_a [4] = '{126, 127, 0, 1};
        run_xfer(126, 4, 1'b0, 0, -1, -1, 0, 0, 10);
        checks++; if (q_data.size() != 4) begin failures++; $display("FAIL wrap_beats: got %0d expected 4", q_data.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (q_addr[k] != exp_a[k]) begin failures++; $display("FAIL wrap_addr%0d: got %0d expected %0d", k, q_addr[k], exp_a[k]); end
            checks++; if (q_data[k] !== 8'(exp_a[k])) begin failures++; $display("FAIL wrap_data%0d: got %0d expected %0d", k, q_data[k], exp_a[k]); end
            checks++; if (q_last[k] !== (k == 3)) begin failures++; $display("FAIL wrap_last%0d: got %0b expected %0b", k, q_last[k], k == 3); end
        end
        checks++; if (q_done.size() != 1 || q_done[0] != 7) begin failures++; $display("FAIL wrap_done: got n=%0d first=%0d expected n=1 cycle 7", q_done.size(), q_done[0]); end
    endtask

    task automatic test_backpressure();
        int exp_c [5] = '{4, 6, 8, 10, 12};
        run_xfer(40, 5, 1'b0, 1, -1, -1, 0, 0, 30);
        checks++; if (q_data.size() != 5) begin failures++; $display("FAIL bp_beats: got %0d expected 5", q_data.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (q_data[k] !== 8'(40 + k)) begin failures++; $display("FAIL bp_data%0d: got %0d expected %0d", k, q_data[k], 40 + k); end
            checks++; if (q_last[k] !== (k == 4)) begin failures++; $display("FAIL bp_last%0d: got %0b expected %0b", k, q_last[k], k == 4); end
            checks++; if (q_bcyc[k] != exp_c[k]) begin failures++; $display("FAIL bp_bcyc%0d: got %0d expected %0d", k, q_bcyc[k], exp_c[k]); end
        end
        checks++; if (q_addr.size() != 5) begin failures++; $display("FAIL bp_reads: got %0d expected 5", q_addr.size()); end
        checks++; if (credit_viol != 0) begin failures++; $display("FAIL bp_credit: got %0d violations expected 0", credit_viol); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_hold: got %0d violations expected 0", stall_viol); end
        checks++; if (q_done.size() != 1 || q_done[0] != 13) begin failures++; $display("FAIL bp_done: got n=%0d first=%0d expected n=1 cycle 13", q_done.size(), q_done[0]); end
    endtask

    task automatic test_zero_length();
        run_xfer(5, 0, 1'b0, 0, -1, -1, 0, 0, 5);
        checks++; if (q_addr.size() != 0) begin failures++; $display("FAIL zero_reads: got %0d expected 0", q_addr.size()); end
        checks++; if (q_data.size() != 0) begin failures++; $display("FAIL zero_beats: got %0d expected 0", q_data.size()); end
        checks++; if (q_done.size() != 1 || q_done[0] != 1) begin failures++; $display("FAIL zero_done: got n=%0d first=%0d expected n=1 cycle 1", q_done.size(), q_done[0]); end
        checks++; if (busy_low_cyc != 2) begin failures++; $display("FAIL zero_busy_low: got %0d expected 2", busy_low_cyc); end
    endtask

    task automatic test_abort();
        run_xfer(0, 10, 1'b0, 0, 4, -1, 0, 0, 12);
        checks++; if (q_data.size() != 2) begin failures++; $display("FAIL abort_beats: got %0d expected 2", q_data.size()); end
        checks++; if (valid_after_abort != 0) begin failures++; $display("FAIL abort_valid: got %0d valid cycles expected 0", valid_after_abort); end
        checks++; if (q_done.size() != 0) begin failures++; $display("FAIL abort_done: got %0d pulses expected 0", q_done.size()); end
        checks++; if (busy_low_cyc != 5) begin failures++; $display("FAIL abort_busy_low: got %0d expected 5", busy_low_cyc); end
        run_xfer(20, 1, 1'b0, 0, -1, -1, 0, 0, 8);
        checks++; if (q_data.size() != 1) begin failures++; $display("FAIL after_abort_beats: got %0d expected 1", q_data.size()); end
        checks++; if (q_data[0] !== 8'd20) begin failures++; $display("FAIL after_abort_data: got %0d expected 20", q_data[0]); end
        checks++; if (q_last[0] !== 1'b1) begin failures++; $display("FAIL after_abort_last: got %0b expected 1", q_last[0]); end
        checks++; if (q_bcyc[0] != 3) begin failures++; $display("FAIL after_abort_bcyc: got %0d expected 3", q_bcyc[0]); end
        checks++; if (q_done.size() != 1 || q_done[0] != 4) begin failures++; $display("FAIL after_abort_done: got n=%0d first=%0d expected n=1 cycle 4", q_done.size(), q_done[0]); end
    endtask

    task automatic test_back_to_back();
        // Second start at cycle 2 must be ignored; the run stops at cycle 6 so
        // the next command lands on the DUT's first IDLE cycle.
        run_xfer(60, 3, 1'b0, 0, -1, 2, 0, 5, 7);
        checks++; if (q_data.size() != 3) begin failures++; $display("FAIL b2b_first_beats: got %0d expected 3", q_data.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (q_data[k] !== 8'(60 + k)) begin failures++; $display("FAIL b2b_first_data%0d: got %0d expected %0d", k, q_data[k], 60 + k); end
        end
        checks++; if (q_done.size() != 1 || q_done[0] != 6) begin failures++; $display("FAIL b2b_first_done: got n=%0d first=%0d expected n=1 cycle 6", q_done.size(), q_done[0]); end
        run_xfer(70, 2, 1'b0, 0, -1, -1, 0, 0, 8);
        checks++; if (q_data.size() != 2) begin failures++; $display("FAIL b2b_second_beats: got %0d expected 2", q_data.size()); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (q_data[k] !== 8'(70 + k)) begin failures++; $display("FAIL b2b_second_data%0d: got %0d expected %0d", k, q_data[k], 70 + k); end
            checks++; if (q_bcyc[k] != 3 + k) begin failures++; $display("FAIL b2b_second_bcyc%0d: got %0d expected %0d", k, q_bcyc[k], 3 + k); end
        end
        checks++; if (q_last[1] !== 1'b1) begin failures++; $display("FAIL b2b_second_last: got %0b expected 1", q_last[1]); end
        checks++; if (q_done.size() != 1 || q_done[0] != 5) begin failures++; $display("FAIL b2b_second_done: got n=%0d first=%0d expected n=1 cycle 5", q_done.size(), q_done[0]); end
    endtask

    task automatic test_loop();
`ifdef FILE_STREAM_LOOP_EN
        run_xfer(10, 3, 1'b1, 0, 16, -1, 0, 0, 20);
        checks++; if (q_data.size() < 12) begin failures++; $display("FAIL loop_beats: got %0d expected >= 12", q_data.size()); end
        for (int k = 0; k < 12; k++) begin
            checks++; if (q_data[k] !== 8'(10 + k % 3)) begin failures++; $display("FAIL loop_data%0d: got %0d expected %0d", k, q_data[k], 10 + k % 3); end
            checks++; if (q_last[k] !== (k % 3 == 2)) begin failures++; $display("FAIL loop_last%0d: got %0b expected %0b", k, q_last[k], k % 3 == 2); end
            checks++; if (q_bcyc[k] != 3 + k) begin failures++; $display("FAIL loop_bcyc%0d: got %0d expected %0d", k, q_bcyc[k], 3 + k); end
        end
        checks++; if (q_done.size() != 0) begin failures++; $display("FAIL loop_done: got %0d pulses expected 0", q_done.size()); end
        checks++; if (busy_low_cyc != 17) begin failures++; $display("FAIL loop_busy_low: got %0d expected 17", busy_low_cyc); end
`else
        run_xfer(10, 3, 1'b1, 0, -1, -1, 0, 0, 10);
        checks++; if (q_data.size() != 3) begin failures++; $display("FAIL noloop_beats: got %0d expected 3", q_data.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (q_data[k] !== 8'(10 + k)) begin failures++; $display("FAIL noloop_data%0d: got %0d expected %0d", k, q_data[k], 10 + k); end
        end
        checks++; if (q_done.size() != 1 || q_done[0] != 6) begin failures++; $display("FAIL noloop_done: got n=%0d first=%0d expected n=1 cycle 6", q_done.size(), q_done[0]); end
        checks++; if (busy_low_cyc != 7) begin failures++; $display("FAIL noloop_busy_low: got %0d expected 7", busy_low_cyc); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_abort();
        test_back_to_back();
        test_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/file_stream_controller.md
# file_stream_controller

Sequences reads from the processor's 128×8 program/file memory and streams the bytes to a downstream consumer over a valid/ready handshake. A command (base address, length) starts a transfer. The block issues one read per cycle into the memory's 1-cycle-latency read port and buffers returned bytes in a 2-entry output buffer, so backpressure never loses data. It sits between the file memory and the instruction loader/decoder.

## Interface
- ADDR_W, 7, memory address width
- DATA_W, 8, data width
- DEPTH, 128, memory depth (must equal 2**ADDR_W)

- clock  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  command strobe, sampled in IDLE only
- base_addr  in  ADDR_W  first address of transfer
- length  in  ADDR_W+1  byte count, 0..DEPTH
- loop  in  1  repeat transfer (effective only with FILE_STREAM_LOOP_EN)
- abort  in  1  cancel current transfer
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on normal completion
- mem_rd_en  out  1  memory read request
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en
- out_data  out  DATA_W  stream byte
- out_valid  out  1  stream byte valid
- out_ready  in  1  consumer accepts byte
- out_last  out  1  marks final byte of a pass

## Operation
- States: IDLE, RUN (reads outstanding), DRAIN (all reads issued, buffer not empty), DONE (one cycle) → IDLE.
- IDLE + start, length>0: latch base/length/loop, rd_ptr=base, remaining=length → RUN. With length=0: → DONE directly, no reads, no beats. start outside IDLE is ignored.
- Read credit: mem_rd_en asserted in RUN when (buffer occupancy + in-flight read − pop this cycle) < 2. Each read: mem_addr=rd_ptr, rd_ptr+=1 modulo DEPTH (127 wraps to 0), remaining−=1.
- remaining reaches 0 → DRAIN. Returned bytes are written to the buffer in the cycle mem_rd_data is valid.
- Buffer: 2-entry FIFO, head drives out_data/out_valid. Pop on out_valid && out_ready. out_data holds stable while out_valid && !out_ready.
- out_last=1 on the beat corresponding to the pass's final address.
- DRAIN → DONE when last beat handshakes. DONE asserts done for exactly one cycle.
- abort (RUN/DRAIN/DONE): next cycle → IDLE. Buffer flushed, in-flight return discarded, out_valid=0, done not pulsed. abort in IDLE: no effect. abort has priority over start and over handshake completion in the same cycle.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_last=0; state IDLE; buffer empty.
- start in cycle 0: RUN in cycle 1, first mem_rd_en in cycle 1, first out_valid in cycle 3.
- With out_ready held high: 1 byte/cycle. N bytes: last read in cycle N, last beat in cycle N+2, done in cycle N+3, busy low from cycle N+4.
- length=0: done in cycle 1, busy low in cycle 2.
- out_ready low: at most 2 bytes buffered, reads stall, no byte dropped or duplicated.

## Configuration
- FILE_STREAM_LOOP_EN defined: if loop was latched high, after the last read of a pass, rd_ptr reloads base and remaining reloads length, with no gap. out_last marks each pass's final byte. done never pulses. The transfer ends only via abort or reset.
- Undefined: loop input ignored. Every transfer ends in DONE after one pass.

## Test plan
- Reset mid-RUN with 2 bytes buffered → all outputs at reset values immediately, IDLE; next start behaves normally.
- base=0, length=4, ready=1, memory[i]=i → beats 0,1,2,3 on cycles 3–6, out_last on 3, done cycle 7.
- base=126, length=4 → addresses 126,127,0,1; data order matches; out_last on byte from address 1.
- length=5, out_ready toggled 1/0 every cycle → 5 beats in order, none lost or repeated; mem_rd_en never issued with 2 occupied + in-flight.
- abort in cycle 4 of a length=10 transfer → out_valid=0 from cycle 5, no done; a new start (base=20, length=1) yields memory[20] with out_last.
- FILE_STREAM_LOOP_EN, loop=1, base=10, length=3 → 10,11,12,10,11,12,… with out_last on every address-12 byte, no done until abort.
